// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS day-masked alarms with ring timeout and global ack.
// Define ALARM_BANK_SNOOZE_EN to build the bounded snooze path (SNOOZED state).
module alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int RING_MIN   = 3,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3,
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  min_tick,
    input  logic [6:0]            tmin,
    input  logic [6:0]            thrs,
    input  logic [2:0]            tdays,
    input  logic                  prog_we,
    input  logic [IW-1:0]         prog_idx,
    input  logic [6:0]            prog_min,
    input  logic [6:0]            prog_hrs,
    input  logic [6:0]            prog_days,
    input  logic                  prog_on,
    input  logic                  ack,
    input  logic                  snooze,
    output logic                  buzz,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic [NUM_ALARMS-1:0] snoozed
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } state_t;

    logic [6:0]            cfg_min_q  [NUM_ALARMS];
    logic [6:0]            cfg_hrs_q  [NUM_ALARMS];
    logic [6:0]            cfg_days_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] cfg_on_q;

    state_t                st_q   [NUM_ALARMS];
    state_t                st_d   [NUM_ALARMS];
    logic [5:0]            ring_q [NUM_ALARMS];
    logic [5:0]            ring_d [NUM_ALARMS];
`ifdef ALARM_BANK_SNOOZE_EN
    logic [5:0]            snz_q  [NUM_ALARMS];
    logic [5:0]            snz_d  [NUM_ALARMS];
    logic [2:0]            used_q [NUM_ALARMS];
    logic [2:0]            used_d [NUM_ALARMS];
`else
    logic                  unused_snz;
    assign unused_snz = ^{snooze, 6'(SNOOZE_MIN), 3'(MAX_SNOOZE)};
`endif

    logic [NUM_ALARMS-1:0] prog_hit;
    logic [NUM_ALARMS-1:0] match;
    logic                  buzz_q;
    logic                  buzz_d;

    // An out-of-range prog_idx decodes to no channel, so the write is dropped.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            prog_hit[i] = prog_we && (prog_idx == IW'(i));
            match[i]    = min_tick && cfg_on_q[i] && (tmin == cfg_min_q[i]) &&
                          (thrs == cfg_hrs_q[i]) && (tdays != 3'd7) &&
                          cfg_days_q[i][tdays];
        end
    end

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the priority chain can leave one unassigned and infer a latch.
    always_comb begin
        buzz_d = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            st_d[i]   = st_q[i];
            ring_d[i] = ring_q[i];
`ifdef ALARM_BANK_SNOOZE_EN
            snz_d[i]  = snz_q[i];
            used_d[i] = used_q[i];
`endif
            if (prog_hit[i]) begin
                st_d[i]   = ST_IDLE;
                ring_d[i] = '0;
`ifdef ALARM_BANK_SNOOZE_EN
                snz_d[i]  = '0;
                used_d[i] = '0;
`endif
            end else if (ack) begin
                st_d[i]   = ST_IDLE;
                ring_d[i] = '0;
`ifdef ALARM_BANK_SNOOZE_EN
                snz_d[i]  = '0;
            end else if (snooze && (st_q[i] == ST_RINGING) &&
                         (used_q[i] < 3'(MAX_SNOOZE))) begin
                st_d[i]   = ST_SNOOZED;
                snz_d[i]  = 6'(SNOOZE_MIN);
                used_d[i] = used_q[i] + 3'd1;
`endif
            end else if (min_tick) begin
                case (st_q[i])
                    ST_IDLE: begin
                        if (match[i]) begin
                            st_d[i]   = ST_RINGING;
                            ring_d[i] = 6'(RING_MIN);
`ifdef ALARM_BANK_SNOOZE_EN
                            used_d[i] = '0;
`endif
                        end
                    end
                    ST_RINGING: begin
                        if (ring_q[i] == 6'd1) begin
                            st_d[i]   = ST_IDLE;
                            ring_d[i] = '0;
                        end else begin
                            ring_d[i] = ring_q[i] - 6'd1;
                        end
                    end
`ifdef ALARM_BANK_SNOOZE_EN
                    ST_SNOOZED: begin
                        if (snz_q[i] == 6'd1) begin
                            st_d[i]   = ST_RINGING;
                            ring_d[i] = 6'(RING_MIN);
                            snz_d[i]  = '0;
                        end else begin
                            snz_d[i]  = snz_q[i] - 6'd1;
                        end
                    end
`endif
                    default: st_d[i] = ST_IDLE;
                endcase
            end
            buzz_d = buzz_d | (st_d[i] == ST_RINGING);
        end
    end

    // NOTE: the configuration array is a handful of flops, not a RAM, and
    // must read as cleared after reset, so it sits in the reset branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                cfg_min_q[i]  <= '0;
                cfg_hrs_q[i]  <= '0;
                cfg_days_q[i] <= '0;
                st_q[i]       <= ST_IDLE;
                ring_q[i]     <= '0;
`ifdef ALARM_BANK_SNOOZE_EN
                snz_q[i]      <= '0;
                used_q[i]     <= '0;
`endif
            end
            cfg_on_q <= '0;
            buzz_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every channel sees the same
            // pre-edge state regardless of statement order.
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (prog_hit[i]) begin
                    cfg_min_q[i]  <= prog_min;
                    cfg_hrs_q[i]  <= prog_hrs;
                    cfg_days_q[i] <= prog_days;
                    cfg_on_q[i]   <= prog_on;
                end
                st_q[i]   <= st_d[i];
                ring_q[i] <= ring_d[i];
`ifdef ALARM_BANK_SNOOZE_EN
                snz_q[i]  <= snz_d[i];
                used_q[i] <= used_d[i];
`endif
            end
            buzz_q <= buzz_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            ringing[i] = (st_q[i] == ST_RINGING);
`ifdef ALARM_BANK_SNOOZE_EN
            snoozed[i] = (st_q[i] == ST_SNOOZED);
`else
            snoozed[i] = 1'b0;
`endif
        end
    end

    assign buzz = buzz_q;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed vectors; stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against buzz/ringing/snoozed.
module tb_alarm_bank;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          min_tick;
    logic [6:0]    tmin;
    logic [6:0]    thrs;
    logic [2:0]    tdays;
    logic          prog_we;
    logic [IW-1:0] prog_idx;
    logic [6:0]    prog_min;
    logic [6:0]    prog_hrs;
    logic [6:0]    prog_days;
    logic          prog_on;
    logic          ack;
    logic          snooze;
    logic          buzz;
    logic [N-1:0]  ringing;
    logic [N-1:0]  snoozed;

    alarm_bank #(
        .NUM_ALARMS(N),
        .RING_MIN  (3),
        .SNOOZE_MIN(5),
        .MAX_SNOOZE(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .min_tick (min_tick),
        .tmin     (tmin),
        .thrs     (thrs),
        .tdays    (tdays),
        .prog_we  (prog_we),
        .prog_idx (prog_idx),
        .prog_min (prog_min),
        .prog_hrs (prog_hrs),
        .prog_days(prog_days),
        .prog_on  (prog_on),
        .ack      (ack),
        .snooze   (snooze),
        .buzz     (buzz),
        .ringing  (ringing),
        .snoozed  (snoozed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        string        tag;
        logic         b;
        logic [N-1:0] r;
        logic [N-1:0] s;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [2*N:0] got, input logic [2*N:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: {buzz,ringing,snoozed} got %b required %b", tag, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s: expectation for cycle %0d not sampled, now %0d", e.tag, e.cyc, cyc);
                end else begin
                    check(e.tag, {buzz, ringing, snoozed}, {e.b, e.r, e.s});
                end
            end
        end
    end

    // Queue the outputs expected after the coming edge, take the edge, drop pulses.
    task automatic cycle(input string tag, input logic b, input logic [N-1:0] r, input logic [N-1:0] s);
        sb.push_back('{cyc: cyc + 1, tag: tag, b: b, r: r, s: s});
        @(negedge clk);
        min_tick = 1'b0;
        ack      = 1'b0;
        snooze   = 1'b0;
        prog_we  = 1'b0;
    endtask

    task automatic prog(input int idx, input int mn, input int hr, input logic [6:0] days, input logic on);
        prog_we   = 1'b1;
        prog_idx  = IW'(idx);
        prog_min  = 7'(mn);
        prog_hrs  = 7'(hr);
        prog_days = days;
        prog_on   = on;
    endtask

    task automatic at(input int mn, input int hr, input int dy);
        min_tick = 1'b1;
        tmin     = 7'(mn);
        thrs     = 7'(hr);
        tdays    = 3'(dy);
    endtask

`ifdef ALARM_BANK_SNOOZE_EN
    // Four snoozed ticks, then the fifth returns ch1 to RINGING.
    task automatic snz_wait();
        for (int k = 0; k < 4; k++) begin
            m++;
            at(m, 10, 4);
            cycle("s_wait", 1'b0, 4'b0000, 4'b0010);
        end
        m++;
        at(m, 10, 4);
        cycle("s_rering", 1'b1, 4'b0010, 4'b0000);
    endtask
`endif

    initial begin
        rst = 1'b1;
        {min_tick, ack, snooze, prog_we, prog_on} = '0;
        {tmin, thrs, tdays, prog_idx, prog_min, prog_hrs, prog_days} = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {buzz, ringing, snoozed}, '0);
        rst = 1'b0;

        cycle("idle", 1'b0, 4'b0000, 4'b0000);
        at(0, 0, 0);
        cycle("reset_cfg_silent", 1'b0, 4'b0000, 4'b0000);

        // Weekday alarm rings for exactly three ticks after the trigger.
        prog(0, 30, 7, 7'b0111110, 1'b1);
        cycle("t1_prog", 1'b0, 4'b0000, 4'b0000);
        at(30, 7, 1);
        cycle("t1_trig", 1'b1, 4'b0001, 4'b0000);
        cycle("t1_hold", 1'b1, 4'b0001, 4'b0000);
        at(31, 7, 1);
        cycle("t1_tick1", 1'b1, 4'b0001, 4'b0000);
        at(32, 7, 1);
        cycle("t1_tick2", 1'b1, 4'b0001, 4'b0000);
        at(33, 7, 1);
        cycle("t1_tick3_stop", 1'b0, 4'b0000, 4'b0000);

        // Day mask, the never-matching day 7, and a disabled channel.
        at(30, 7, 0);
        cycle("t2_sunday_off", 1'b0, 4'b0000, 4'b0000);
        prog(0, 30, 7, 7'b0111111, 1'b1);
        cycle("t2_prog", 1'b0, 4'b0000, 4'b0000);
        at(30, 7, 0);
        cycle("t2_sunday_on", 1'b1, 4'b0001, 4'b0000);
        ack = 1'b1;
        cycle("t2_ack", 1'b0, 4'b0000, 4'b0000);
        prog(0, 30, 7, 7'h7f, 1'b1);
        cycle("t2_prog_all", 1'b0, 4'b0000, 4'b0000);
        at(30, 7, 7);
        cycle("t2_day7_never", 1'b0, 4'b0000, 4'b0000);
        prog(0, 30, 7, 7'h7f, 1'b0);
        cycle("t2_prog_off", 1'b0, 4'b0000, 4'b0000);
        at(30, 7, 2);
        cycle("t2_off_silent", 1'b0, 4'b0000, 4'b0000);

        // Two channels on the same time, ack, then ack together with snooze.
        prog(0, 0, 8, 7'h7f, 1'b1);
        cycle("t4_prog0", 1'b0, 4'b0000, 4'b0000);
        prog(2, 0, 8, 7'h7f, 1'b1);
        cycle("t4_prog2", 1'b0, 4'b0000, 4'b0000);
        at(0, 8, 3);
        cycle("t4_both", 1'b1, 4'b0101, 4'b0000);
        ack = 1'b1;
        cycle("t4_ack", 1'b0, 4'b0000, 4'b0000);
        at(0, 8, 3);
        cycle("t4_retrig", 1'b1, 4'b0101, 4'b0000);
        ack    = 1'b1;
        snooze = 1'b1;
        cycle("t4_ack_snooze", 1'b0, 4'b0000, 4'b0000);

        // Reprogramming kills a ringing channel; reset acts without a clock edge.
        prog(3, 15, 9, 7'h7f, 1'b1);
        cycle("t5_prog", 1'b0, 4'b0000, 4'b0000);
        at(15, 9, 2);
        cycle("t5_trig", 1'b1, 4'b1000, 4'b0000);
        at(16, 9, 2);
        prog(3, 15, 9, 7'h7f, 1'b1);
        cycle("t5_prog_kill", 1'b0, 4'b0000, 4'b0000);
        at(15, 9, 2);
        cycle("t5_retrig", 1'b1, 4'b1000, 4'b0000);
        #1 rst = 1'b1;
        #1 check("t5_async_reset", {buzz, ringing, snoozed}, '0);
        @(negedge clk);
        rst = 1'b0;
        at(15, 9, 2);
        cycle("t5_cfg_cleared", 1'b0, 4'b0000, 4'b0000);

        // Snooze behaviour on ch1 at 10:00.
        prog(1, 0, 10, 7'h7f, 1'b1);
        cycle("s_prog", 1'b0, 4'b0000, 4'b0000);
        at(0, 10, 4);
        cycle("s_trig", 1'b1, 4'b0010, 4'b0000);
`ifdef ALARM_BANK_SNOOZE_EN
        at(1, 10, 4);
        cycle("s_ring1", 1'b1, 4'b0010, 4'b0000);
        at(2, 10, 4);
        cycle("s_ring2", 1'b1, 4'b0010, 4'b0000);
        at(3, 10, 4);
        snooze = 1'b1;
        cycle("s_last_tick_snooze", 1'b0, 4'b0000, 4'b0010);
        snooze = 1'b1;
        cycle("s_snooze_in_snoozed", 1'b0, 4'b0000, 4'b0010);
        m = 3;
        snz_wait();
        snooze = 1'b1;
        cycle("s_snooze2", 1'b0, 4'b0000, 4'b0010);
        snz_wait();
        snooze = 1'b1;
        cycle("s_snooze3", 1'b0, 4'b0000, 4'b0010);
        snz_wait();
        snooze = 1'b1;
        cycle("s_limit_ignored", 1'b1, 4'b0010, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            m++;
            at(m, 10, 4);
            cycle("s_final_ring", 1'b1, 4'b0010, 4'b0000);
        end
        m++;
        at(m, 10, 4);
        cycle("s_final_stop", 1'b0, 4'b0000, 4'b0000);
`else
        snooze = 1'b1;
        cycle("n_snooze_ignored", 1'b1, 4'b0010, 4'b0000);
        at(1, 10, 4);
        snooze = 1'b1;
        cycle("n_tick1", 1'b1, 4'b0010, 4'b0000);
        at(2, 10, 4);
        cycle("n_tick2", 1'b1, 4'b0010, 4'b0000);
        at(3, 10, 4);
        snooze = 1'b1;
        cycle("n_tick3_stop", 1'b0, 4'b0000, 4'b0000);
`endif

        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
